// File: rtl/regfile_mp_if.sv
// +--------------------------------------------------------------------------+
// | regfile_mp_if                                                            |
// | Read/write/clear bus of the multi-read-port register file.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface regfile_mp_if #(
  parameter int dataN    = 32,
  parameter int addressN = 5,
  parameter int rdPortN  = 2
);
  logic [rdPortN*addressN-1:0] ra;
  logic [rdPortN*dataN-1:0]    rd;
  logic                        we;
  logic [addressN-1:0]         wa;
  logic [dataN-1:0]            wd;
  logic                        clr;
  logic                        busy;
  logic                        done;

  modport master (output ra, we, wa, wd, clr, input rd, busy, done);
  modport slave  (input ra, we, wa, wd, clr, output rd, busy, done);
endinterface

`default_nettype wire

// File: rtl/regfile_mp.sv
// +--------------------------------------------------------------------------+
// | regfile_mp                                                               |
// | Register file: N combinational read ports, one write port, optional      |
// | hardwired-zero entry 0 and a self-timed bulk clear sequencer.            |
// | Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module regfile_mp #(
  parameter int dataN    = 32,
  parameter int addressN = 5,
  parameter int rdPortN  = 2,
  parameter bit zeroReg  = 1'b1
) (
  input  wire logic   clk,
  input  wire logic   rstn,
  regfile_mp_if.slave bus
);

  localparam int                  DEPTH    = 1 << addressN;
  localparam logic [addressN-1:0] LAST_IDX = '1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_d;
  logic [addressN-1:0] r_idx;
  logic [addressN-1:0] w_idx_d;
  logic                r_done;
  logic                w_done_d;
  logic                w_wr_en;

  logic [dataN-1:0] r_mem     [DEPTH];
  logic [dataN-1:0] w_rd_port [rdPortN];

  // External writes only land while idle; entry 0 is immutable when hardwired.
  assign w_wr_en = bus.we && (r_state == IDLE) &&
                   !(zeroReg && (bus.wa == '0));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_done  <= w_done_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_done_d  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.clr) begin
          w_state_d = CLEAR;
          w_idx_d   = '0;
        end
      end
      CLEAR: begin
        if (r_idx == LAST_IDX) begin
          w_state_d = IDLE;
          w_idx_d   = '0;
          w_done_d  = 1'b1;
        end else begin
          w_idx_d = r_idx + addressN'(1);
        end
      end
      default: begin
        w_state_d = IDLE;
        w_idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (r_state == CLEAR) begin
      r_mem[r_idx] <= '0;
    end else if (w_wr_en) begin
      r_mem[bus.wa] <= bus.wd;
    end
  end

  for (genvar k = 0; k < rdPortN; k++) begin : g_rd
    logic [addressN-1:0] w_addr;
    logic                w_bypass;

    assign w_addr = bus.ra[k*addressN +: addressN];
`ifdef REGFILE_BYPASS_EN
    // w_wr_en is already false during CLEAR, so nothing forwards there.
    assign w_bypass = w_wr_en && (bus.wa == w_addr);
`else
    assign w_bypass = 1'b0;
`endif
    assign w_rd_port[k] = w_bypass                        ? bus.wd :
                          (zeroReg && (w_addr == '0))     ? '0     :
                                                            r_mem[w_addr];
  end

  always_comb begin
    bus.rd = '0;
    for (int k = 0; k < rdPortN; k++) begin
      bus.rd[k*dataN +: dataN] = w_rd_port[k];
    end
  end

  assign bus.busy = (r_state == CLEAR);
  assign bus.done = r_done;

endmodule

`default_nettype wire
